instr_sequencer: RTL and testbench

//   Sequences instruction issue into the processor control unit.

---
 rtl/seq_pkg.sv | 25 ++
 rtl/instr_fifo.sv | 62 ++++++
 rtl/instr_sequencer.sv | 166 ++++++++++++++++
 tb/tb_instr_sequencer.sv | 422 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/seq_pkg.sv
// Shared types and field positions for the instruction sequencer.
package seq_pkg;

    localparam int FUNC_W  = 24;
    localparam int OPC_MSB = 23;
    localparam int OPC_LSB = 20;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_ISSUE,
        ST_WAIT,
        ST_HALT
    } state_t;

    typedef enum logic {
        SRC_ROM,
        SRC_HOST
    } src_t;

    function automatic logic is_halt(input logic [FUNC_W-1:0] word, input logic [3:0] halt_opc);
        return word[OPC_MSB:OPC_LSB] == halt_opc;
    endfunction

endpackage

// File: rtl/instr_fifo.sv
// Synchronous FIFO for host-submitted instruction words; the head is read
// combinationally, so a word written at one edge is visible after that edge.
module instr_fifo #(
    parameter int WIDTH = 24,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             wr_en, rd_en;

    assign full  = (count_q == CNT_W'(DEPTH));
    assign empty = (count_q == '0);
    assign count = count_q;
    assign dout  = mem_q[rd_ptr_q];
    assign wr_en = push && !full;
    assign rd_en = pop && !empty;

    // NOTE: every output of a combinational block gets a default first, so no path leaves it unassigned and infers a latch.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (wr_en) wr_ptr_d = wr_ptr_q + 1'b1;
        if (rd_en) rd_ptr_d = rd_ptr_q + 1'b1;
        count_d = count_q + CNT_W'(wr_en) - CNT_W'(rd_en);
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // NOTE: storage is deliberately not reset; the pointers and count alone define which entries are valid.
    always_ff @(posedge clk) begin
        if (wr_en) mem_q[wr_ptr_q] <= din;
    end

endmodule

// File: rtl/instr_sequencer.sv
// Issues instructions from ROM or a host FIFO to the control unit, one at a time.
// Optional WAIT watchdog enabled by defining SEQ_WATCHDOG_EN (adds wdog_err).
module instr_sequencer
    import seq_pkg::*;
#(
    parameter int         FIFO_DEPTH  = 4,
    parameter logic [3:0] HALT_OPCODE = 4'hF,
    parameter int         WDOG_CYCLES = 255
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          run,
    input  logic                          mode_mem,
    input  logic [FUNC_W-1:0]             host_func,
    input  logic                          host_valid,
    output logic                          host_ready,
    input  logic [FUNC_W-1:0]             rom_func,
    input  logic                          ins_done,
    output logic [FUNC_W-1:0]             func_out,
    output logic                          new_ins,
    output logic                          pc_start,
    output logic                          pc_step,
    output logic                          busy,
    output logic                          halted,
`ifdef SEQ_WATCHDOG_EN
    output logic                          wdog_err,
`endif
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

    state_t            state_q, state_d;
    src_t              src_q, src_d;
    logic [FUNC_W-1:0] func_out_q, func_out_d;
    logic              new_ins_q, new_ins_d;
    logic              pc_start_q, pc_start_d;
    logic              pc_step_q, pc_step_d;
    logic [FUNC_W-1:0] fifo_head, word;
    logic              fifo_full, fifo_empty, fifo_pop;

`ifdef SEQ_WATCHDOG_EN
    localparam int WDOG_W = $clog2(WDOG_CYCLES + 1);
    logic [WDOG_W-1:0] wdog_cnt_q, wdog_cnt_d;
    logic              wdog_err_q, wdog_err_d;
`endif

    instr_fifo #(
        .WIDTH (FUNC_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (host_valid),
        .pop   (fifo_pop),
        .din   (host_func),
        .dout  (fifo_head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    assign word = (src_q == SRC_ROM) ? rom_func : fifo_head;

    always_comb begin
        state_d    = state_q;
        src_d      = src_q;
        func_out_d = func_out_q;
        new_ins_d  = 1'b0;
        pc_start_d = 1'b0;
        pc_step_d  = 1'b0;
        fifo_pop   = 1'b0;
`ifdef SEQ_WATCHDOG_EN
        wdog_cnt_d = (state_q == ST_WAIT) ? wdog_cnt_q + 1'b1 : '0;
        wdog_err_d = wdog_err_q;
`endif
        unique case (state_q)
            ST_IDLE: begin
                if (run && mode_mem) begin
                    state_d    = ST_FETCH;
                    src_d      = SRC_ROM;
                    pc_start_d = 1'b1;
                end else if (run && !fifo_empty) begin
                    state_d = ST_ISSUE;
                    src_d   = SRC_HOST;
                end
            end
            ST_FETCH: state_d = ST_ISSUE;
            ST_ISSUE: begin
                func_out_d = word;
                fifo_pop   = (src_q == SRC_HOST) && !fifo_empty;
                if (is_halt(word, HALT_OPCODE)) begin
                    state_d = ST_HALT;
                end else begin
                    new_ins_d = 1'b1;
                    state_d   = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (ins_done) begin
                    if (src_q == SRC_ROM) begin
                        // The PC always advances so a later restart resumes at the next word.
                        pc_step_d = 1'b1;
                        state_d   = run ? ST_FETCH : ST_IDLE;
                    end else begin
                        state_d = (run && !fifo_empty) ? ST_ISSUE : ST_IDLE;
                    end
                end
`ifdef SEQ_WATCHDOG_EN
                else if (wdog_cnt_q == WDOG_W'(WDOG_CYCLES - 1)) begin
                    state_d    = ST_HALT;
                    wdog_err_d = 1'b1;
                end
`endif
            end
            ST_HALT: begin
                if (!run) begin
                    state_d = ST_IDLE;
`ifdef SEQ_WATCHDOG_EN
                    wdog_err_d = 1'b0;
`endif
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q    <= ST_IDLE;
            src_q      <= SRC_ROM;
            func_out_q <= '0;
            new_ins_q  <= 1'b0;
            pc_start_q <= 1'b0;
            pc_step_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            src_q      <= src_d;
            func_out_q <= func_out_d;
            new_ins_q  <= new_ins_d;
            pc_start_q <= pc_start_d;
            pc_step_q  <= pc_step_d;
        end
    end

`ifdef SEQ_WATCHDOG_EN
    always_ff @(posedge clk) begin
        if (!reset) begin
            wdog_cnt_q <= '0;
            wdog_err_q <= 1'b0;
        end else begin
            wdog_cnt_q <= wdog_cnt_d;
            wdog_err_q <= wdog_err_d;
        end
    end

    assign wdog_err = wdog_err_q;
`endif

    assign func_out   = func_out_q;
    assign new_ins    = new_ins_q;
    assign pc_start   = pc_start_q;
    assign pc_step    = pc_step_q;
    assign busy       = (state_q != ST_IDLE);
    assign halted     = (state_q == ST_HALT);
    assign host_ready = !fifo_full;

endmodule

// File: tb/tb_instr_sequencer.sv
// Self-checking bench for instr_sequencer: directed scenarios plus randomized
// host traffic checked against a transaction-level queue model.
module tb_instr_sequencer;

    localparam int FIFO_DEPTH = 4;

    logic        clk;
    logic        reset;
    logic        run;
    logic        mode_mem;
    logic [23:0] host_func;
    logic        host_valid;
    logic        host_ready;
    logic [23:0] rom_func;
    logic        ins_done;
    logic [23:0] func_out;
    logic        new_ins;
    logic        pc_start;
    logic        pc_step;
    logic        busy;
    logic        halted;
    logic [2:0]  fifo_count;
`ifdef SEQ_WATCHDOG_EN
    logic        wdog_err;
`endif

    instr_sequencer #(
        .FIFO_DEPTH  (FIFO_DEPTH),
        .HALT_OPCODE (4'hF),
        .WDOG_CYCLES (8)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .run        (run),
        .mode_mem   (mode_mem),
        .host_func  (host_func),
        .host_valid (host_valid),
        .host_ready (host_ready),
        .rom_func   (rom_func),
        .ins_done   (ins_done),
        .func_out   (func_out),
        .new_ins    (new_ins),
        .pc_start   (pc_start),
        .pc_step    (pc_step),
        .busy       (busy),
        .halted     (halted),
`ifdef SEQ_WATCHDOG_EN
        .wdog_err   (wdog_err),
`endif
        .fifo_count (fifo_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Program counter and ROM with combinational read of the current address.
    logic [23:0] rom_mem [4];
    logic [1:0]  pc = 2'd0;
    always @(posedge clk) begin
        if (pc_start)     pc <= 2'd0;
        else if (pc_step) pc <= pc + 2'd1;
    end
    assign rom_func = rom_mem[pc];

    int checks = 0;
    int errors = 0;

    // Reference model: host words in arrival order, one instruction in flight
    // at a time, each issue visible two edges after it becomes possible.
    logic [23:0] model_q [$];
    bit          model_en    = 1'b0;
    bit          outstanding = 1'b0;
    bit          due         = 1'b0;
    bit          exp_new     = 1'b0;
    logic [23:0] exp_word    = '0;

    task automatic tick();
        bit          acc, avail, done, r, rst;
        logic [23:0] w;
        acc   = host_valid && host_ready;
        w     = host_func;
        avail = model_q.size() > 0;
        done  = ins_done;
        r     = run;
        rst   = !reset;
        @(posedge clk);
        #1;
        exp_new = 1'b0;
        if (rst) begin
            model_q.delete();
            outstanding = 1'b0;
            due         = 1'b0;
        end else if (model_en) begin
            if (due) begin
                exp_new     = 1'b1;
                exp_word    = model_q.pop_front();
                due         = 1'b0;
                outstanding = 1'b1;
            end else if (!outstanding && avail && r) begin
                due = 1'b1;
            end else if (outstanding && done) begin
                outstanding = 1'b0;
                if (avail && r) due = 1'b1;
            end
        end
        if (!rst && acc) model_q.push_back(w);
    endtask

    task automatic do_reset();
        reset      = 1'b0;
        run        = 1'b0;
        mode_mem   = 1'b0;
        host_valid = 1'b0;
        ins_done   = 1'b0;
        model_en   = 1'b0;
        tick();
        tick();
        reset = 1'b1;
        tick();
    endtask

    task automatic push_words(input logic [23:0] base, input int n);
        for (int i = 0; i < n; i++) begin
            host_valid = 1'b1;
            host_func  = base + 24'(i);
            tick();
        end
        host_valid = 1'b0;
    endtask

    // Serves the control-unit side with random ins_done delays while pushing
    // up to push_budget random non-HALT words, checking every cycle.
    task automatic serve_host(input int max_cycles, input int push_budget);
        int         pushes = 0;
        int         delay  = -1;
        int         cyc    = 0;
        logic [3:0] op;
        while (cyc < max_cycles) begin
            op         = 4'($urandom_range(0, 14));
            host_func  = {op, 20'($urandom)};
            host_valid = (pushes < push_budget) && ($urandom_range(0, 99) < 50);
            if (host_valid && host_ready) pushes++;
            ins_done = (delay == 0);
            tick();
            ins_done = 1'b0;
            if (delay == 0)     delay = -1;
            else if (delay > 0) delay--;
            checks++;
            if (new_ins !== exp_new) begin
                errors++;
                $display("FAIL serve_new_ins t=%0t got=%b exp=%b", $time, new_ins, exp_new);
            end
            if (exp_new) begin
                checks++;
                if (func_out !== exp_word) begin
                    errors++;
                    $display("FAIL serve_func_out t=%0t got=%h exp=%h", $time, func_out, exp_word);
                end
            end
            if (new_ins) delay = $urandom_range(0, 4);
            checks++;
            if (fifo_count !== 3'(model_q.size()) || host_ready !== (model_q.size() < FIFO_DEPTH)) begin
                errors++;
                $display("FAIL serve_fifo t=%0t count=%0d ready=%b exp_count=%0d",
                         $time, fifo_count, host_ready, model_q.size());
            end
            if (pushes >= push_budget && model_q.size() == 0 && !outstanding && !due && delay < 0) break;
            cyc++;
        end
        host_valid = 1'b0;
        checks++;
        if (cyc >= max_cycles) begin
            errors++;
            $display("FAIL serve_timeout after %0d cycles, queue=%0d", cyc, model_q.size());
        end
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL serve_idle_at_end busy=%b exp=0", busy);
        end
    endtask

    task automatic test_reset();
        reset      = 1'b0;
        run        = 1'b1;
        mode_mem   = 1'b1;
        host_valid = 1'b0;
        host_func  = '0;
        ins_done   = 1'b0;
        tick();
        tick();
        checks++;
        if ({func_out, new_ins, pc_start, pc_step, busy, halted, host_ready, fifo_count} !== {24'h0, 5'b00000, 1'b1, 3'd0}) begin
            errors++;
            $display("FAIL reset_state func=%h new=%b start=%b step=%b busy=%b halt=%b ready=%b count=%0d",
                     func_out, new_ins, pc_start, pc_step, busy, halted, host_ready, fifo_count);
        end
        do_reset();
    endtask

    task automatic test_host_mode();
        do_reset();
        push_words(24'h100001, 3);
        checks++;
        if (fifo_count !== 3'd3) begin
            errors++;
            $display("FAIL host_preload count=%0d exp=3", fifo_count);
        end
        model_en = 1'b1;
        run      = 1'b1;
        serve_host(100, 0);
        checks++;
        if (fifo_count !== 3'd0) begin
            errors++;
            $display("FAIL host_final_count count=%0d exp=0", fifo_count);
        end
    endtask

    task automatic test_fifo_full();
        do_reset();
        for (int i = 0; i < 5; i++) begin
            host_valid = 1'b1;
            host_func  = 24'h300000 + 24'(i);
            checks++;
            if (host_ready !== (i < FIFO_DEPTH)) begin
                errors++;
                $display("FAIL full_ready push=%0d got=%b exp=%b", i, host_ready, (i < FIFO_DEPTH));
            end
            tick();
        end
        host_valid = 1'b0;
        checks++;
        if (fifo_count !== 3'd4 || host_ready !== 1'b0) begin
            errors++;
            $display("FAIL full_state count=%0d ready=%b exp count=4 ready=0", fifo_count, host_ready);
        end
        model_en = 1'b1;
        run      = 1'b1;
        serve_host(200, 0);
    endtask

    task automatic test_rom_mode();
        bit          e_start, e_step, e_new, e_halt;
        logic [23:0] e_func;
        int          n_start = 0;
        int          n_step  = 0;
        do_reset();
        rom_mem[0] = 24'h200000;
        rom_mem[1] = 24'h200001;
        rom_mem[2] = 24'hF00000;
        rom_mem[3] = 24'h200003;
        run      = 1'b1;
        mode_mem = 1'b1;
        for (int t = 1; t <= 11; t++) begin
            ins_done   = (t == 4) || (t == 7);
            host_valid = (t == 10);
            host_func  = 24'h4A0000;
            tick();
            ins_done   = 1'b0;
            host_valid = 1'b0;
            if (pc_start) n_start++;
            if (pc_step)  n_step++;
            e_start = (t == 1);
            e_step  = (t == 4) || (t == 7);
            e_new   = (t == 3) || (t == 6);
            e_halt  = (t >= 9);
            checks++;
            if ({pc_start, pc_step, new_ins, halted} !== {e_start, e_step, e_new, e_halt}) begin
                errors++;
                $display("FAIL rom_seq t=%0d start=%b step=%b new=%b halt=%b exp %b%b%b%b",
                         t, pc_start, pc_step, new_ins, halted, e_start, e_step, e_new, e_halt);
            end
            if (t == 3 || t == 6 || t == 9) begin
                e_func = (t == 3) ? 24'h200000 : (t == 6) ? 24'h200001 : 24'hF00000;
                checks++;
                if (func_out !== e_func) begin
                    errors++;
                    $display("FAIL rom_func t=%0d got=%h exp=%h", t, func_out, e_func);
                end
            end
        end
        checks++;
        if (n_start != 1 || n_step != 2 || fifo_count !== 3'd1) begin
            errors++;
            $display("FAIL rom_totals starts=%0d steps=%0d count=%0d exp 1/2/1", n_start, n_step, fifo_count);
        end
        run = 1'b0;
        tick();
        checks++;
        if (halted !== 1'b0 || busy !== 1'b0 || func_out !== 24'hF00000) begin
            errors++;
            $display("FAIL rom_halt_exit halt=%b busy=%b func=%h exp 0/0/f00000", halted, busy, func_out);
        end
        mode_mem = 1'b0;
    endtask

    task automatic test_done_in_issue();
        do_reset();
        push_words(24'h510000, 2);
        model_en = 1'b1;
        run      = 1'b1;
        tick();
        ins_done = 1'b1;
        tick();
        ins_done = 1'b0;
        checks++;
        if (new_ins !== 1'b1 || exp_new !== 1'b1 || func_out !== 24'h510000) begin
            errors++;
            $display("FAIL issue_first new=%b func=%h exp new=1 func=510000", new_ins, func_out);
        end
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++;
            if (new_ins !== 1'b0 || busy !== 1'b1) begin
                errors++;
                $display("FAIL issue_done_ignored cyc=%0d new=%b busy=%b exp new=0 busy=1", i, new_ins, busy);
            end
        end
        ins_done = 1'b1;
        tick();
        ins_done = 1'b0;
        tick();
        checks++;
        if (new_ins !== 1'b1 || func_out !== 24'h510001) begin
            errors++;
            $display("FAIL issue_second new=%b func=%h exp new=1 func=510001", new_ins, func_out);
        end
        ins_done = 1'b1;
        tick();
        ins_done = 1'b0;
    endtask

    task automatic test_back_to_back();
        do_reset();
        model_en = 1'b1;
        run      = 1'b1;
        serve_host(4000, 300);
    endtask

    task automatic test_reset_mid();
        do_reset();
        push_words(24'h600000, 3);
        model_en = 1'b1;
        run      = 1'b1;
        tick();
        tick();
        checks++;
        if (new_ins !== 1'b1 || fifo_count !== 3'd2) begin
            errors++;
            $display("FAIL midreset_setup new=%b count=%0d exp new=1 count=2", new_ins, fifo_count);
        end
        reset = 1'b0;
        tick();
        checks++;
        if ({busy, halted, new_ins, host_ready, fifo_count, func_out} !== {4'b0001, 3'd0, 24'h0}) begin
            errors++;
            $display("FAIL midreset_state busy=%b halt=%b new=%b ready=%b count=%0d func=%h",
                     busy, halted, new_ins, host_ready, fifo_count, func_out);
        end
        reset = 1'b1;
        run   = 1'b0;
        tick();
    endtask

`ifdef SEQ_WATCHDOG_EN
    task automatic test_watchdog();
        do_reset();
        push_words(24'h700000, 1);
        run = 1'b1;
        tick();
        tick();
        checks++;
        if (new_ins !== 1'b1 || wdog_err !== 1'b0) begin
            errors++;
            $display("FAIL wdog_issue new=%b err=%b exp 1/0", new_ins, wdog_err);
        end
        repeat (7) tick();
        checks++;
        if (halted !== 1'b0) begin
            errors++;
            $display("FAIL wdog_early halt=%b exp=0", halted);
        end
        tick();
        checks++;
        if (halted !== 1'b1 || wdog_err !== 1'b1) begin
            errors++;
            $display("FAIL wdog_trip halt=%b err=%b exp 1/1", halted, wdog_err);
        end
        run = 1'b0;
        tick();
        checks++;
        if (halted !== 1'b0 || wdog_err !== 1'b0) begin
            errors++;
            $display("FAIL wdog_clear halt=%b err=%b exp 0/0", halted, wdog_err);
        end
    endtask
`endif

    initial begin
        host_func = '0;
        for (int i = 0; i < 4; i++) rom_mem[i] = '0;
        test_reset();
        test_host_mode();
        test_fifo_full();
        test_rom_mode();
        test_done_in_issue();
        test_back_to_back();
        test_reset_mid();
`ifdef SEQ_WATCHDOG_EN
        test_watchdog();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL global_timeout reached at t=%0t", $time);
        $fatal(1, "simulation time limit");
    end

endmodule
